rr_arb: RTL and testbench

Round-robin arbiter granting one of N requestors access to a shared downstream valid/ready channel, with packet locking across multi-beat transfers. It produces the one-hot winner vector and consumes the unary priority mask derived from the last winner by an instantiated `mask` (TOWARDS_LSB=0, INCLUSIVE=0). It sits in front of shared queue write ports and crossbars.

---
 rtl/rr_arb.sv | 125 ++++++++++++
 tb/tb_rr_arb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/rr_arb.sv
// Round-robin arbiter onto one valid/ready channel; the grant locks to a requestor
// until its last beat is accepted, including a first offer that stalls.

module mask #(
    parameter int W           = 4,
    parameter bit TOWARDS_LSB = 1'b0,
    parameter bit INCLUSIVE   = 1'b0
) (
    input  logic [W-1:0] i_vec,
    output logic [W-1:0] o_msk
);
    logic seen;
    int   idx;

    // Running OR swept away from the source bit; exclusive mode writes before accumulating.
    always_comb begin
        o_msk = '0;
        seen  = 1'b0;
        idx   = 0;
        for (int i = 0; i < W; i++) begin
            idx = TOWARDS_LSB ? (W - 1 - i) : i;
            if (INCLUSIVE) seen = seen | i_vec[idx];
            o_msk[idx] = seen;
            if (!INCLUSIVE) seen = seen | i_vec[idx];
        end
    end
endmodule

module rr_arb #(
    parameter int N = 4,
    localparam int EW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_req_vld,
    input  logic [N-1:0]  i_req_last,
    output logic [N-1:0]  o_req_rdy,
    output logic [N-1:0]  o_gnt,
    output logic [EW-1:0] o_gnt_enc,
    output logic          o_vld,
    output logic          o_last,
    input  logic          i_rdy
);
    typedef enum logic {ARB, LOCK} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] pri_q, pri_d;
    logic [N-1:0] own_q, own_d;
    logic [N-1:0] msk, req_m, win;
    logic [N-1:0] gnt;
    logic         vld, last, acc;

    function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
        logic [N-1:0] r;
        logic         found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    mask #(.W(N), .TOWARDS_LSB(1'b0), .INCLUSIVE(1'b0)) u_mask (
        .i_vec (pri_q),
        .o_msk (msk)
    );

    always_comb begin
        req_m = i_req_vld & msk;
        win   = lowest((req_m != '0) ? req_m : i_req_vld);
        if (state_q == LOCK) begin
            gnt = own_q;
            vld = |(i_req_vld & own_q);
        end else begin
            gnt = win;
            vld = |i_req_vld;
        end
        last = |(gnt & i_req_last & i_req_vld);
        acc  = vld & i_rdy;
    end

    // Any offer that is not a completed last beat pins the grant, so stalls never switch it.
    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        own_d   = own_q;
        if (acc && last) pri_d = gnt;
        if (state_q == ARB) begin
            if (vld && !(i_rdy && last)) begin
                state_d = LOCK;
                own_d   = gnt;
            end
        end else if (acc && last) begin
            state_d = ARB;
            own_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            pri_q   <= N'(1) << (N - 1);
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            own_q   <= own_d;
        end
    end

    always_comb begin
        o_gnt     = rst ? '0 : gnt;
        o_vld     = !rst && vld;
        o_last    = !rst && last;
        o_req_rdy = (!rst && acc) ? gnt : '0;
        o_gnt_enc = '0;
        for (int i = 0; i < N; i++) begin
            if (o_gnt[i]) o_gnt_enc = EW'(i);
        end
    end
endmodule

// File: tb/tb_rr_arb.sv
// Directed vector table for rr_arb (N=4) plus a hand-written lock sequence on an N=1 instance.

module tb_rr_arb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_vld = '0, req_last = '0;
    logic       rdy = 1'b0;
    logic [3:0] req_rdy, gnt;
    logic [1:0] gnt_enc;
    logic       vld, last;

    logic       rst1 = 1'b1, vld1_in = 1'b0, last1_in = 1'b0, rdy1 = 1'b0;
    logic       req_rdy1, gnt1, enc1, vld1, olast1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arb #(.N(4)) dut (
        .clk(clk), .rst(rst), .i_req_vld(req_vld), .i_req_last(req_last),
        .o_req_rdy(req_rdy), .o_gnt(gnt), .o_gnt_enc(gnt_enc), .o_vld(vld),
        .o_last(last), .i_rdy(rdy)
    );

    rr_arb #(.N(1)) dut1 (
        .clk(clk), .rst(rst1), .i_req_vld(vld1_in), .i_req_last(last1_in),
        .o_req_rdy(req_rdy1), .o_gnt(gnt1), .o_gnt_enc(enc1), .o_vld(vld1),
        .o_last(olast1), .i_rdy(rdy1)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lst;
        logic       rdy;
        logic [3:0] e_gnt;
        logic       e_vld;
        logic [3:0] e_rdy;
        logic [1:0] e_enc;
        logic       e_last;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] ls, input logic rd,
                       input logic [3:0] eg, input logic ev, input logic [3:0] er,
                       input logic [1:0] ee, input logic el);
        vec_t v;
        v = '{r, rq, ls, rd, eg, ev, er, ee, el};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        //   rst req     last    rdy  gnt     vld rdy_o   enc  last
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0, 0);  // 0 reset
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 4'b0001, 0, 1);  // rotation 0,1,2,3,0
        add(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 4'b0010, 1, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 4'b0100, 2, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 4'b1000, 3, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 4'b0001, 0, 1);  // 5
        add(1, 4'b0101, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0, 0);  // alternate 0,2
        add(0, 4'b0101, 4'b1111, 1, 4'b0001, 1, 4'b0001, 0, 1);
        add(0, 4'b0101, 4'b1111, 1, 4'b0100, 1, 4'b0100, 2, 1);
        add(0, 4'b0101, 4'b1111, 1, 4'b0001, 1, 4'b0001, 0, 1);
        add(0, 4'b0101, 4'b1111, 1, 4'b0100, 1, 4'b0100, 2, 1);  // 10
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0, 0);  // 3-beat packet from 1
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 4'b0001, 0, 1);
        add(0, 4'b1111, 4'b1101, 1, 4'b0010, 1, 4'b0010, 1, 0);
        add(0, 4'b1111, 4'b1101, 1, 4'b0010, 1, 4'b0010, 1, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 4'b0010, 1, 1);  // 15
        add(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 4'b0100, 2, 1);
        add(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0, 0);  // stalled grant to 2
        add(0, 4'b0100, 4'b1111, 0, 4'b0100, 1, 4'b0000, 2, 1);
        add(0, 4'b0101, 4'b1111, 0, 4'b0100, 1, 4'b0000, 2, 1);
        add(0, 4'b0101, 4'b1111, 0, 4'b0100, 1, 4'b0000, 2, 1);  // 20
        add(0, 4'b0101, 4'b1111, 0, 4'b0100, 1, 4'b0000, 2, 1);
        add(0, 4'b0101, 4'b1111, 0, 4'b0100, 1, 4'b0000, 2, 1);
        add(0, 4'b0101, 4'b1111, 1, 4'b0100, 1, 4'b0100, 2, 1);
        add(0, 4'b1101, 4'b1111, 1, 4'b1000, 1, 4'b1000, 3, 1);
        add(0, 4'b0101, 4'b1111, 1, 4'b0001, 1, 4'b0001, 0, 1);  // 25
        add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0);  // reset mid-lock on 3
        add(0, 4'b1000, 4'b0000, 1, 4'b1000, 1, 4'b1000, 3, 0);
        add(0, 4'b1001, 4'b0000, 1, 4'b1000, 1, 4'b1000, 3, 0);
        add(1, 4'b1001, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0, 0);
        add(0, 4'b1001, 4'b1111, 1, 4'b0001, 1, 4'b0001, 0, 1);  // 30
        add(0, 4'b0100, 4'b1111, 1, 4'b0100, 1, 4'b0100, 2, 1);  // lone requestor 2
        add(0, 4'b0100, 4'b1111, 1, 4'b0100, 1, 4'b0100, 2, 1);
        add(0, 4'b0100, 4'b1111, 1, 4'b0100, 1, 4'b0100, 2, 1);
        add(0, 4'b0100, 4'b0000, 1, 4'b0100, 1, 4'b0100, 2, 0);  // owner drops valid mid-packet
        add(0, 4'b1001, 4'b1111, 1, 4'b0100, 0, 4'b0000, 2, 0);  // 35
        add(0, 4'b0101, 4'b1111, 1, 4'b0100, 1, 4'b0100, 2, 1);
        add(0, 4'b1001, 4'b1111, 1, 4'b1000, 1, 4'b1000, 3, 1);
        add(0, 4'b0000, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            req_vld  = vecs[i].req;
            req_last = vecs[i].lst;
            rdy      = vecs[i].rdy;
            #1;
            chk("gnt",     i, 32'(gnt),     32'(vecs[i].e_gnt));
            chk("vld",     i, 32'(vld),     32'(vecs[i].e_vld));
            chk("req_rdy", i, 32'(req_rdy), 32'(vecs[i].e_rdy));
            chk("gnt_enc", i, 32'(gnt_enc), 32'(vecs[i].e_enc));
            chk("last",    i, 32'(last),    32'(vecs[i].e_last));
        end

        // N=1: lock holds across a dropped valid and releases on the last beat.
        @(negedge clk); rst1 = 1'b1; vld1_in = 1'b1; last1_in = 1'b0; rdy1 = 1'b1;
        #1; chk("n1_rst_gnt", 0, 32'(gnt1), 32'd0);
        @(negedge clk); rst1 = 1'b0;
        #1; chk("n1_gnt", 1, 32'(gnt1), 32'd1);
        chk("n1_rdy", 1, 32'(req_rdy1), 32'd1);
        @(negedge clk); vld1_in = 1'b0;
        #1; chk("n1_lock_gnt", 2, 32'(gnt1), 32'd1);
        chk("n1_lock_vld", 2, 32'(vld1), 32'd0);
        @(negedge clk); vld1_in = 1'b1; last1_in = 1'b1;
        #1; chk("n1_last", 3, 32'(olast1), 32'd1);
        chk("n1_enc", 3, 32'(enc1), 32'd0);
        @(negedge clk); vld1_in = 1'b0;
        #1; chk("n1_idle_gnt", 4, 32'(gnt1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
